// File: rtl/mips_fetch_unit.sv
// Instruction-fetch / PC stage feeding mips_decode: fetches over req/ready, holds the word, picks next PC on accept.
// Optional FETCH_EPC_EN adds an epc output capturing the PC of the last excepting accept.
module mips_fetch_unit #(
    parameter logic [31:0] RESET_PC   = 32'h0040_0000,
    parameter logic [31:0] EXC_VECTOR = 32'h8000_0180
) (
    input  logic        clock,
    input  logic        reset,
    output logic        imem_req,
    output logic [31:0] imem_addr,
    input  logic        imem_ready,
    input  logic [31:0] imem_rdata,
    input  logic        stall,
    input  logic [1:0]  control_type,
    input  logic        except,
    input  logic [31:0] rs_data,
    output logic [31:0] inst,
    output logic        inst_valid,
    output logic [5:0]  opcode,
    output logic [5:0]  funct,
    output logic [31:0] pc,
    output logic [31:0] pc_plus4,
`ifdef FETCH_EPC_EN
    output logic [31:0] epc,
`endif
    output logic [31:0] instr_count
);

    localparam int unsigned XLEN = 32;

    localparam logic [1:0] CT_SEQ    = 2'd0;
    localparam logic [1:0] CT_BRANCH = 2'd1;
    localparam logic [1:0] CT_J      = 2'd2;
    localparam logic [1:0] CT_JR     = 2'd3;

    typedef enum logic {
        FETCH = 1'b0,
        VALID = 1'b1
    } state_t;

    state_t            r_state;
    logic [XLEN-1:0]   r_pc;
    logic [XLEN-1:0]   r_inst;
    logic [XLEN-1:0]   r_instr_count;
    logic              r_imem_req;
    logic              r_inst_valid;
`ifdef FETCH_EPC_EN
    logic [XLEN-1:0]   r_epc;
`endif

    logic [XLEN-1:0]   w_pc_plus4;
    logic [XLEN-1:0]   w_branch_off;
    logic [XLEN-1:0]   w_next_pc;
    logic              w_unused_rs_lo;

    assign w_pc_plus4     = r_pc + XLEN'(4);
    assign w_branch_off   = {{14{r_inst[15]}}, r_inst[15:0], 2'b00};
    assign w_unused_rs_lo = ^rs_data[1:0];

    // Next-PC select; exception redirect overrides the decoded control type.
    always_comb begin
        w_next_pc = w_pc_plus4;
        if (except) begin
            w_next_pc = EXC_VECTOR;
        end else begin
            case (control_type)
                CT_SEQ:    w_next_pc = w_pc_plus4;
                CT_BRANCH: w_next_pc = w_pc_plus4 + w_branch_off;
                CT_J:      w_next_pc = {w_pc_plus4[31:28], r_inst[25:0], 2'b00};
                CT_JR:     w_next_pc = {rs_data[31:2], 2'b00};
                default:   w_next_pc = w_pc_plus4;
            endcase
        end
    end

    // Fetch/hold sequencer with registered handshake outputs.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            r_state       <= FETCH;
            r_pc          <= RESET_PC;
            r_inst        <= '0;
            r_instr_count <= '0;
            r_imem_req    <= 1'b1;
            r_inst_valid  <= 1'b0;
`ifdef FETCH_EPC_EN
            r_epc         <= '0;
`endif
        end else begin
            case (r_state)
                FETCH: begin
                    if (imem_ready) begin
                        r_inst       <= imem_rdata;
                        r_state      <= VALID;
                        r_imem_req   <= 1'b0;
                        r_inst_valid <= 1'b1;
                    end
                end
                VALID: begin
                    if (!stall) begin
                        r_pc          <= w_next_pc;
                        r_instr_count <= r_instr_count + XLEN'(1);
                        r_state       <= FETCH;
                        r_imem_req    <= 1'b1;
                        r_inst_valid  <= 1'b0;
`ifdef FETCH_EPC_EN
                        if (except) begin
                            r_epc <= r_pc;
                        end
`endif
                    end
                end
                default: begin
                    r_state      <= FETCH;
                    r_imem_req   <= 1'b1;
                    r_inst_valid <= 1'b0;
                end
            endcase
        end
    end

    assign imem_req    = r_imem_req;
    assign imem_addr   = r_pc;
    assign inst        = r_inst;
    assign inst_valid  = r_inst_valid;
    assign opcode      = r_inst[31:26];
    assign funct       = r_inst[5:0];
    assign pc          = r_pc;
    assign pc_plus4    = w_pc_plus4;
    assign instr_count = r_instr_count;
`ifdef FETCH_EPC_EN
    assign epc         = r_epc;
`endif

endmodule

// File: tb/tb_mips_fetch_unit.sv
// Directed bench for mips_fetch_unit: reset, sequential/branch/jump/jr redirects, stall, exception, wait, wrap.
// Define FETCH_EPC_EN on both bench and RTL to exercise the epc output.
module tb_mips_fetch_unit;

    logic        clock;
    logic        reset;
    logic        imem_req;
    logic [31:0] imem_addr;
    logic        imem_ready;
    logic [31:0] imem_rdata;
    logic        stall;
    logic [1:0]  control_type;
    logic        except;
    logic [31:0] rs_data;
    logic [31:0] inst;
    logic        inst_valid;
    logic [5:0]  opcode;
    logic [5:0]  funct;
    logic [31:0] pc;
    logic [31:0] pc_plus4;
    logic [31:0] instr_count;
`ifdef FETCH_EPC_EN
    logic [31:0] epc;
`endif

    int n_vec;
    int n_err;

    mips_fetch_unit dut (
        .clock        (clock),
        .reset        (reset),
        .imem_req     (imem_req),
        .imem_addr    (imem_addr),
        .imem_ready   (imem_ready),
        .imem_rdata   (imem_rdata),
        .stall        (stall),
        .control_type (control_type),
        .except       (except),
        .rs_data      (rs_data),
        .inst         (inst),
        .inst_valid   (inst_valid),
        .opcode       (opcode),
        .funct        (funct),
        .pc           (pc),
        .pc_plus4     (pc_plus4),
`ifdef FETCH_EPC_EN
        .epc          (epc),
`endif
        .instr_count  (instr_count)
    );

    initial begin
        clock = 1'b0;
        forever #5 clock = ~clock;
    end

    // Advance one clock; inputs change and outputs are sampled 1ns after the edge.
    task automatic step();
        @(posedge clock);
        #1;
    endtask

    // Present one word on a bounded FETCH wait; leaves the DUT in VALID.
    task automatic do_fetch(input logic [31:0] word);
        int waited = 0;
        while (imem_req !== 1'b1 && waited < 20) begin
            step();
            waited++;
        end
        if (waited >= 20) begin
            n_vec++; n_err++;
            $display("FAIL fetch_timeout: imem_req=%b required 1", imem_req);
        end
        imem_ready = 1'b1;
        imem_rdata = word;
        step();
        imem_ready = 1'b0;
        imem_rdata = 32'hDEAD_BEEF;
    endtask

    // Accept the held instruction with the given decoder outcome.
    task automatic do_accept(input logic [1:0] ct, input logic exc, input logic [31:0] rs);
        stall        = 1'b0;
        control_type = ct;
        except       = exc;
        rs_data      = rs;
        step();
        control_type = 2'd0;
        except       = 1'b0;
        rs_data      = 32'h0;
    endtask

    task automatic test_reset();
        reset = 1'b0;
        step();
        step();
        n_vec++; if (imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL reset_addr: got %h want %h", imem_addr, 32'h0040_0000); end
        n_vec++; if (inst_valid !== 1'b0) begin n_err++; $display("FAIL reset_valid: got %b want 0", inst_valid); end
        n_vec++; if (instr_count !== 32'h0) begin n_err++; $display("FAIL reset_count: got %h want 0", instr_count); end
        n_vec++; if (inst !== 32'h0) begin n_err++; $display("FAIL reset_inst: got %h want 0", inst); end
`ifdef FETCH_EPC_EN
        n_vec++; if (epc !== 32'h0) begin n_err++; $display("FAIL reset_epc: got %h want 0", epc); end
`endif
        reset = 1'b1;
        #1;
        n_vec++; if (imem_req !== 1'b1) begin n_err++; $display("FAIL release_req: got %b want 1", imem_req); end
    endtask

    task automatic test_sequential();
        n_vec++; if (imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL seq_first_addr: got %h want %h", imem_addr, 32'h0040_0000); end
        do_fetch(32'h2008_0005);
        n_vec++; if (inst_valid !== 1'b1) begin n_err++; $display("FAIL seq_valid: got %b want 1", inst_valid); end
        n_vec++; if (imem_req !== 1'b0) begin n_err++; $display("FAIL seq_req_low: got %b want 0", imem_req); end
        n_vec++; if (opcode !== 6'h08) begin n_err++; $display("FAIL seq_opcode: got %h want 08", opcode); end
        n_vec++; if (funct !== 6'h05) begin n_err++; $display("FAIL seq_funct: got %h want 05", funct); end
        n_vec++; if (pc_plus4 !== 32'h0040_0004) begin n_err++; $display("FAIL seq_pc_plus4: got %h want %h", pc_plus4, 32'h0040_0004); end
        do_accept(2'd0, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h0040_0004) begin n_err++; $display("FAIL seq_next_addr: got %h want %h", imem_addr, 32'h0040_0004); end
        n_vec++; if (instr_count !== 32'd1) begin n_err++; $display("FAIL seq_count: got %0d want 1", instr_count); end
        n_vec++; if (inst_valid !== 1'b0 || imem_req !== 1'b1) begin n_err++; $display("FAIL seq_refetch: valid=%b req=%b want 0/1", inst_valid, imem_req); end
    endtask

    task automatic test_branch();
        // j from 0x00400004 to 0x00400010 to set up the branch pc
        do_fetch(32'h0810_0004);
        do_accept(2'd2, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h0040_0010) begin n_err++; $display("FAIL br_setup_addr: got %h want %h", imem_addr, 32'h0040_0010); end
        do_fetch(32'h1000_FFFF);
        do_accept(2'd1, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h0040_0010) begin n_err++; $display("FAIL br_back_addr: got %h want %h", imem_addr, 32'h0040_0010); end
        do_fetch(32'h1000_0003);
        n_vec++; if (pc !== 32'h0040_0010) begin n_err++; $display("FAIL br_held_pc: got %h want %h", pc, 32'h0040_0010); end
        do_accept(2'd1, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h0040_0020) begin n_err++; $display("FAIL br_fwd_addr: got %h want %h", imem_addr, 32'h0040_0020); end
        n_vec++; if (instr_count !== 32'd4) begin n_err++; $display("FAIL br_count: got %0d want 4", instr_count); end
    endtask

    task automatic test_jump();
        do_fetch(32'h0000_0008);
        do_accept(2'd3, 1'b0, 32'h0040_0000);
        n_vec++; if (imem_addr !== 32'h0040_0000) begin n_err++; $display("FAIL jr_home_addr: got %h want %h", imem_addr, 32'h0040_0000); end
        do_fetch(32'h0810_0010);
        do_accept(2'd2, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h0040_0040) begin n_err++; $display("FAIL j_addr: got %h want %h", imem_addr, 32'h0040_0040); end
        do_fetch(32'h0000_0008);
        do_accept(2'd3, 1'b0, 32'h0040_0103);
        n_vec++; if (imem_addr !== 32'h0040_0100) begin n_err++; $display("FAIL jr_align_addr: got %h want %h", imem_addr, 32'h0040_0100); end
    endtask

    task automatic test_stall_except();
        do_fetch(32'h1234_5678);
        stall        = 1'b1;
        control_type = 2'd1;
        except       = 1'b1;
        for (int i = 0; i < 5; i++) begin
            imem_ready = 1'b1;
            imem_rdata = 32'hCAFE_0000 + 32'(i);
            step();
            n_vec++; if (inst !== 32'h1234_5678 || pc !== 32'h0040_0100) begin n_err++; $display("FAIL stall_hold_%0d: inst=%h pc=%h want 12345678/00400100", i, inst, pc); end
            n_vec++; if (instr_count !== 32'd7 || imem_req !== 1'b0 || inst_valid !== 1'b1) begin n_err++; $display("FAIL stall_ctl_%0d: count=%0d req=%b valid=%b want 7/0/1", i, instr_count, imem_req, inst_valid); end
        end
        imem_ready = 1'b0;
`ifdef FETCH_EPC_EN
        n_vec++; if (epc !== 32'h0) begin n_err++; $display("FAIL epc_before: got %h want 0", epc); end
`endif
        do_accept(2'd1, 1'b1, 32'h0);
        n_vec++; if (imem_addr !== 32'h8000_0180) begin n_err++; $display("FAIL exc_addr: got %h want %h", imem_addr, 32'h8000_0180); end
        n_vec++; if (instr_count !== 32'd8) begin n_err++; $display("FAIL exc_count: got %0d want 8", instr_count); end
`ifdef FETCH_EPC_EN
        n_vec++; if (epc !== 32'h0040_0100) begin n_err++; $display("FAIL epc_capture: got %h want %h", epc, 32'h0040_0100); end
`endif
    endtask

    task automatic test_wait_reset();
        imem_ready = 1'b0;
        for (int i = 0; i < 4; i++) begin
            step();
            n_vec++; if (imem_req !== 1'b1 || inst_valid !== 1'b0 || imem_addr !== 32'h8000_0180) begin n_err++; $display("FAIL wait_%0d: req=%b valid=%b addr=%h want 1/0/80000180", i, imem_req, inst_valid, imem_addr); end
        end
        #2;
        reset = 1'b0;
        #1;
        n_vec++; if (pc !== 32'h0040_0000) begin n_err++; $display("FAIL async_reset_pc: got %h want %h", pc, 32'h0040_0000); end
        n_vec++; if (instr_count !== 32'h0) begin n_err++; $display("FAIL async_reset_count: got %h want 0", instr_count); end
`ifdef FETCH_EPC_EN
        n_vec++; if (epc !== 32'h0) begin n_err++; $display("FAIL async_reset_epc: got %h want 0", epc); end
`endif
        step();
        reset = 1'b1;
    endtask

    task automatic test_wrap();
        do_fetch(32'h0000_0008);
        do_accept(2'd3, 1'b0, 32'hFFFF_FFFF);
        n_vec++; if (imem_addr !== 32'hFFFF_FFFC) begin n_err++; $display("FAIL wrap_setup_addr: got %h want %h", imem_addr, 32'hFFFF_FFFC); end
        do_fetch(32'h0000_0000);
        n_vec++; if (pc_plus4 !== 32'h0) begin n_err++; $display("FAIL wrap_pc_plus4: got %h want 0", pc_plus4); end
        stall = 1'b1;
        force dut.r_instr_count = 32'hFFFF_FFFF;
        #1;
        release dut.r_instr_count;
        #1;
        n_vec++; if (instr_count !== 32'hFFFF_FFFF) begin n_err++; $display("FAIL wrap_preload: got %h want ffffffff", instr_count); end
        do_accept(2'd0, 1'b0, 32'h0);
        n_vec++; if (imem_addr !== 32'h0) begin n_err++; $display("FAIL wrap_addr: got %h want 0", imem_addr); end
        n_vec++; if (instr_count !== 32'h0) begin n_err++; $display("FAIL wrap_count: got %h want 0", instr_count); end
    endtask

    initial begin
        n_vec        = 0;
        n_err        = 0;
        reset        = 1'b0;
        imem_ready   = 1'b0;
        imem_rdata   = 32'h0;
        stall        = 1'b0;
        control_type = 2'd0;
        except       = 1'b0;
        rs_data      = 32'h0;
        test_reset();
        test_sequential();
        test_branch();
        test_jump();
        test_stall_except();
        test_wait_reset();
        test_wrap();
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

endmodule
